display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001: Parameter DIGITS, default 4, number of multiplexed 7-segment digits (2..8).
REQ-002: Parameter DIV, default 100000, clk cycles per digit slot (>=2).
REQ-003: Parameter ACTIVE_LOW, default 1; 1 = seg and an outputs inverted (0 = lit/enabled).
REQ-004: clk  input  1  system clock, sole clock.
REQ-005: rst_n  input  1  asynchronous active-low reset.
REQ-006: digits_bcd  input  4*DIGITS  digit codes, nibble 0 = least significant digit (LSD).
REQ-007: neg  input  1  negative flag, sampled with load.
REQ-008: blank_lz  input  1  leading-zero blanking enable, sampled with load.
REQ-009: load  input  1  single-cycle strobe that captures digits_bcd/neg/blank_lz.
REQ-010: seg  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-011: an  output  DIGITS  digit enables, one-hot or all-off, registered.
REQ-012: frame_done  output  1  one-clk pulse at each frame wrap.

Function
REQ-013: Prescaler counts 0..DIV-1 and wraps; tick asserted in the cycle count==DIV-1; tick is an enable only, no derived clock.
REQ-014: Digit index advances on tick, DIGITS-1 wraps to 0; frame_done is registered high for exactly the cycle after the tick that wraps the index.
REQ-015: load captures inputs into a pending register and sets pending; load while pending overwrites it (last load wins).
REQ-016: On a wrapping tick with pending set, pending contents copy to the active register and pending clears; active never changes mid-frame (no tearing).
REQ-017: load coinciding with a wrapping tick commits the newly loaded data directly and leaves pending clear.
REQ-018: Cycle after any tick: an = all-off (ghost blanking); following cycle: an = one-hot of new index, seg = pattern of that digit.
REQ-019: Patterns (logical, before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; code A = minus 40; codes B-F = blank 00.
REQ-020: Leading-zero blanking (active blank_lz): digits from MSD downward with code 0 show blank until the first nonzero digit; digit 0 never blanked.
REQ-021: Active neg forces digit DIGITS-1 to minus (40), overriding its code and blanking.
REQ-022: ACTIVE_LOW=1 inverts seg and an bitwise at the output register.

Reset
REQ-023: rst_n low immediately forces: prescaler 0, index 0, active and pending registers 0, pending flag 0, frame_done 0, an all-off, seg blank (polarity applied).
REQ-024: After rst_n release, an stays all-off until the first tick sequence per REQ-018; display shows all-zero active data with blanking disabled.
REQ-025: Reset mid-frame discards pending and active data; no commit occurs on release.

Structure
REQ-026: Shared package display_pkg holds segment pattern constants (SEG_0..SEG_9, SEG_MINUS, SEG_BLANK) and digit code constants.
REQ-027: Sub-module seg7_decode: combinational 4-bit code -> 7-bit logical pattern; display_scan instantiates one.

Verification (DIGITS=4, DIV=4, ACTIVE_LOW=1)
REQ-028: Reset, load 0x1234 blank_lz=0 -> after first frame_done, slot an=1110 seg=0x19 ("4"), an=1101 seg=0x30 ("3"), an=1011 seg=0x24 ("2"), an=0111 seg=0x79 ("1").
REQ-029: load 0x0007 blank_lz=1 -> digits 3..1 seg=0x7F, digit 0 seg=0x78; load 0x0000 -> digit 0 shows "0" (0x40).
REQ-030: load 0x0012 neg=1 blank_lz=1 -> digit 3 seg=0x3F (minus), digit 2 0x7F, digit 1 0x79, digit 0 0x24.
REQ-031: load 0x1111 then 0x2222 within one frame -> next frame shows only "2222"; no frame shows 1111; frame_done every 16 clk.
REQ-032: load 0x5555 on the wrapping tick cycle -> following frame shows "5555", pending flag 0.
REQ-033: rst_n low mid-frame -> an=1111, seg=0x7F, frame_done=0 within same cycle; pending load never displayed after release.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared segment patterns and digit code constants for the
//               multiplexed 7-segment display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Logical segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Digit codes with special meaning; B..F all render blank
    localparam logic [3:0] CODE_ZERO  = 4'h0;
    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage : display_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational 4-bit digit code to logical 7-segment pattern.
//               Codes 0-9 are decimal glyphs, A is minus, B-F are blank.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    // Glyph lookup
    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'h0:       pattern = SEG_0;
            4'h1:       pattern = SEG_1;
            4'h2:       pattern = SEG_2;
            4'h3:       pattern = SEG_3;
            4'h4:       pattern = SEG_4;
            4'h5:       pattern = SEG_5;
            4'h6:       pattern = SEG_6;
            4'h7:       pattern = SEG_7;
            4'h8:       pattern = SEG_8;
            4'h9:       pattern = SEG_9;
            CODE_MINUS: pattern = SEG_MINUS;
            default:    pattern = SEG_BLANK;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module      : display_scan
// Description : Time-multiplexed 7-segment scanner with double-buffered digit
//               data (commits only at frame wrap), ghost blanking between
//               slots, leading-zero blanking and a negative sign on the MSD.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan
    import display_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV        = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_bcd,
    input  logic                  neg,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(DIGITS - 1);
    // XOR masks that convert logical (1 = on) values to pin polarity
    localparam logic [6:0]        c_seg_pol  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] c_an_pol   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        c_seg_off  = SEG_BLANK ^ c_seg_pol;
    localparam logic [DIGITS-1:0] c_an_off   = c_an_pol;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_tick_d;
    logic                r_live;
    logic [4*DIGITS-1:0] r_act_digits;
    logic                r_act_neg;
    logic                r_act_blz;
    logic [4*DIGITS-1:0] r_pnd_digits;
    logic                r_pnd_neg;
    logic                r_pnd_blz;
    logic                r_pnd_valid;

    logic                w_tick;
    logic                w_wrap;
    logic [DIGITS-1:0]   w_lz;
    logic [3:0]          w_code;
    logic [3:0]          w_shown_code;
    logic [6:0]          w_pattern;
    logic [DIGITS-1:0]   w_onehot;

    assign w_tick   = (r_cnt == c_cnt_last);
    assign w_wrap   = w_tick && (r_idx == c_idx_last);
    assign w_onehot = DIGITS'(1) << r_idx;

    // Prescaler, slot index, ghost-phase marker and frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_tick_d   <= 1'b0;
            r_live     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_cnt      <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_tick_d   <= w_tick;
            frame_done <= w_wrap;
            if (r_tick_d) begin
                r_live <= 1'b1;
            end
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Double buffer: loads land in pending, pending moves to active only at wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_digits <= '0;
            r_act_neg    <= 1'b0;
            r_act_blz    <= 1'b0;
            r_pnd_digits <= '0;
            r_pnd_neg    <= 1'b0;
            r_pnd_blz    <= 1'b0;
            r_pnd_valid  <= 1'b0;
        end else if (load && w_wrap) begin
            r_act_digits <= digits_bcd;
            r_act_neg    <= neg;
            r_act_blz    <= blank_lz;
            r_pnd_valid  <= 1'b0;
        end else if (load) begin
            r_pnd_digits <= digits_bcd;
            r_pnd_neg    <= neg;
            r_pnd_blz    <= blank_lz;
            r_pnd_valid  <= 1'b1;
        end else if (w_wrap && r_pnd_valid) begin
            r_act_digits <= r_pnd_digits;
            r_act_neg    <= r_pnd_neg;
            r_act_blz    <= r_pnd_blz;
            r_pnd_valid  <= 1'b0;
        end
    end

    // A digit is a leading zero when it and every more significant digit are 0
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lz
            assign w_lz[gi] = (r_act_digits[4*DIGITS-1:4*gi] == '0);
        end
    endgenerate

    // Choose the code for the current slot: sign beats blanking beats data
    always_comb begin
        w_code       = r_act_digits[{r_idx, 2'b00} +: 4];
        w_shown_code = w_code;
        if (r_act_neg && (r_idx == c_idx_last)) begin
            w_shown_code = CODE_MINUS;
        end else if (r_act_blz && (r_idx != '0) && w_lz[r_idx]) begin
            w_shown_code = CODE_BLANK;
        end
    end

    seg7_decode u_decode (
        .code    (w_shown_code),
        .pattern (w_pattern)
    );

    // Output register: all-off for one cycle after every tick, then drive slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= c_seg_off;
            an  <= c_an_off;
        end else if (w_tick) begin
            an  <= c_an_off;
        end else if (r_tick_d || r_live) begin
            an  <= w_onehot ^ c_an_pol;
            seg <= w_pattern ^ c_seg_pol;
        end
    end

endmodule : display_scan
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan
// Description : Self-checking bench for display_scan (DIGITS=4, DIV=4,
//               ACTIVE_LOW=1). A cycle-indexed reference model predicts the
//               scan timing and committed frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_bcd;
    logic        neg;
    logic        blank_lz;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          cyc;
    logic [15:0] m_act;
    bit          m_act_neg;
    bit          m_act_blz;
    logic [15:0] m_pnd;
    bit          m_pnd_neg;
    bit          m_pnd_blz;
    bit          m_pflag;

    display_scan #(
        .DIGITS     (DIGITS),
        .DIV        (DIV),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_bcd (digits_bcd),
        .neg        (neg),
        .blank_lz   (blank_lz),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pin-level segment value expected for digit idx of a frame
    function automatic logic [6:0] ref_glyph(input logic [15:0] d, input bit ng,
                                             input bit blz, input int idx);
        logic [15:0] upper;
        logic [3:0]  code;
        logic [6:0]  lit;
        upper = d >> (4 * idx);
        code  = upper[3:0];
        case (code)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h40;
            default: lit = 7'h00;
        endcase
        if (blz && idx != 0 && upper == 16'h0) lit = 7'h00;
        if (ng && idx == DIGITS - 1) lit = 7'h40;
        return ~lit;
    endfunction

    task automatic model_reset();
        cyc       = 0;
        m_act     = '0;
        m_act_neg = 0;
        m_act_blz = 0;
        m_pnd     = '0;
        m_pnd_neg = 0;
        m_pnd_blz = 0;
        m_pflag   = 0;
    endtask

    // One clock cycle: check outputs of the current cycle, drive inputs, advance
    task automatic step(input bit ld, input logic [15:0] d, input bit ng, input bit blz);
        logic [3:0] exp_an;
        int         slot;
        bit         wrap;
        slot = (cyc / DIV) % DIGITS;
        if (cyc < DIV || cyc % DIV == 0) exp_an = 4'hF;
        else                              exp_an = ~(4'b0001 << slot);
        check("an", an, exp_an);
        check("frame_done", frame_done, (cyc > 0 && cyc % FRAME == 0));
        if (cyc < DIV)
            check("seg_idle", seg, 7'h7F);
        else if (cyc % DIV != 0)
            check("seg", seg, ref_glyph(m_act, m_act_neg, m_act_blz, slot));

        load       = ld;
        digits_bcd = d;
        neg        = ng;
        blank_lz   = blz;

        wrap = (cyc % FRAME == FRAME - 1);
        if (ld && wrap) begin
            m_act = d; m_act_neg = ng; m_act_blz = blz; m_pflag = 0;
        end else if (ld) begin
            m_pnd = d; m_pnd_neg = ng; m_pnd_blz = blz; m_pflag = 1;
        end else if (wrap && m_pflag) begin
            m_act = m_pnd; m_act_neg = m_pnd_neg; m_act_blz = m_pnd_blz; m_pflag = 0;
        end

        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < FRAME && (cyc % FRAME) != phase; i++) step(0, 16'h0, 0, 0);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        for (int k = 0; k < DIGITS; k++)
            v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        digits_bcd = '0;
        neg        = 1'b0;
        blank_lz   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        step(1, 16'h1234, 0, 0);
        idle(40);
        step(1, 16'h0007, 0, 1);
        idle(32);
        step(1, 16'h0000, 0, 1);
        idle(32);
        step(1, 16'h0012, 1, 1);
        idle(32);

        // Two loads inside one frame: only the second may ever appear
        idle_until(2);
        step(1, 16'h1111, 0, 0);
        idle(3);
        step(1, 16'h2222, 0, 0);
        idle(40);

        // Load exactly on the wrapping tick cycle
        idle_until(FRAME - 1);
        step(1, 16'h5555, 0, 0);
        idle(40);

        // Asynchronous reset in the middle of a lit slot with a load pending
        idle_until(6);
        step(1, 16'h9876, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_frame_done", frame_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(40);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0)
                step(1, rand_digits(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                step(0, 16'h0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_display_scan
`default_nettype wire
